multi_ch_integrate_dump: RTL and testbench

// - Multi-channel integrate-and-dump accumulator; parametrised successor of the single-channel sample counter.
// - Sums 1-bit samples (e.g. mixer/correlator outputs) per channel over a runtime-programmable window.
// - Two modes: unsigned ones-count, or signed +/-1 correlation.
// - Dumps all channels at once to a held output register with a valid/ready handshake; feeds downstream tracking logic.

---
 rtl/multi_ch_integrate_dump.sv | 141 ++++++++++++++
 tb/tb_multi_ch_integrate_dump.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_integrate_dump.sv
// Multi-channel integrate-and-dump: per-channel saturating 1-bit accumulators over a
// programmable window, dumped together into a held result register with valid/ready.
module mcid_lane #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             acc_en,
  input  logic             dump,
  input  logic             mode,
  input  logic             smp,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);
  localparam logic [ACC_W-1:0] U_MAX = '1;
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc, nxt;
  logic             sat_acc, clamp;

  // Clamp holds the accumulator at the rail instead of wrapping.
  always_comb begin
    clamp = 1'b0;
    nxt   = acc;
    if (smp) begin
      if (acc == (mode ? S_MAX : U_MAX)) clamp = 1'b1;
      else                              nxt   = acc + ACC_W'(1);
    end else if (mode) begin
      if (acc == S_MIN) clamp = 1'b1;
      else              nxt   = acc - ACC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      sat_acc <= 1'b0;
      sum     <= '0;
      sat     <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (acc_en) begin
      if (dump) begin
        sum     <= nxt;
        sat     <= sat_acc | clamp;
        acc     <= '0;
        sat_acc <= 1'b0;
      end else begin
        acc     <= nxt;
        sat_acc <= sat_acc | clamp;
      end
    end
  end
endmodule

module multi_ch_integrate_dump #(
  parameter int CH      = 4,
  parameter int ACC_W   = 16,
  parameter int WIN_W   = 14,
  parameter int DEF_WIN = 10000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [WIN_W-1:0]    win_len,
  input  logic                en,
  input  logic [CH-1:0]       sample,
  input  logic                out_ready,
  output logic [CH*ACC_W-1:0] sum,
  output logic                out_valid,
  output logic [CH-1:0]       sat,
  output logic                overrun,
  output logic                busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;

  logic [CH-1:0][ACC_W-1:0] sum_arr;
  logic [WIN_W-1:0]         cnt, cnt_inc, len_q;
  logic                     mode_q, go, clr, acc_en, win_end;

  assign busy    = (state == ACCUM);
  assign go      = start & ~stop;
  assign clr     = start | stop;
  // The start/stop cycle's sample is deliberately dropped.
  assign acc_en  = busy & en & ~clr;
  assign cnt_inc = cnt + WIN_W'(1);
  assign win_end = acc_en & (cnt_inc == len_q);
  assign sum     = sum_arr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop)       state_nxt = IDLE;
    else if (start) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      len_q     <= WIN_W'(DEF_WIN);
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clr)         cnt <= '0;
      else if (acc_en) cnt <= win_end ? '0 : cnt_inc;
      if (go) begin
        len_q  <= (win_len == '0) ? WIN_W'(DEF_WIN) : win_len;
        mode_q <= mode;
      end
      if (go)                                      overrun <= 1'b0;
      else if (win_end && out_valid && !out_ready) overrun <= 1'b1;
      if (win_end)        out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    mcid_lane #(.ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc_en (acc_en),
      .dump   (win_end),
      .mode   (mode_q),
      .smp    (sample[i]),
      .sum    (sum_arr[i]),
      .sat    (sat[i])
    );
  end
endmodule

// File: tb/tb_multi_ch_integrate_dump.sv
// Bench for multi_ch_integrate_dump: table-driven windows with a result scoreboard,
// plus hand sequences for back-pressure, saturation (narrow instance), abort and reset.
module tb_multi_ch_integrate_dump;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, mode = 1'b0, en = 1'b0, out_ready = 1'b0;
  logic [13:0] win_len = '0;
  logic [3:0]  sample = '0;
  logic [63:0] sum;
  logic        out_valid, overrun, busy;
  logic [3:0]  sat;
  logic [15:0] sum_s;
  logic        out_valid_s, overrun_s, busy_s;
  logic [3:0]  sat_s;

  multi_ch_integrate_dump #(.CH(4), .ACC_W(16), .WIN_W(14), .DEF_WIN(10000)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .win_len(win_len),
    .en(en), .sample(sample), .out_ready(out_ready), .sum(sum), .out_valid(out_valid),
    .sat(sat), .overrun(overrun), .busy(busy));

  multi_ch_integrate_dump #(.CH(4), .ACC_W(4), .WIN_W(14), .DEF_WIN(10000)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .win_len(win_len),
    .en(en), .sample(sample), .out_ready(out_ready), .sum(sum_s), .out_valid(out_valid_s),
    .sat(sat_s), .overrun(overrun_s), .busy(busy_s));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0, last_cyc = 0;
  bit mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        mode;
    logic [13:0] win_len;
    logic [3:0]  s0, s1;
    logic        en_tgl;
    int          nwin;
    logic [63:0] esum;
    logic [3:0]  esat;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic [3:0]  sat;
    int          gap;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every consumed result must match the oldest expected window.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_sum", sum, e.sum);
        chk("sb_sat", {60'd0, sat}, {60'd0, e.sat});
        chk("sb_gap", 64'(cyc - last_cyc), 64'(e.gap));
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[5];
  logic [3:0] pat[4];

  initial begin
    vt[0] = '{mode:1'b0, win_len:14'd8,  s0:4'b0101, s1:4'b0101, en_tgl:1'b0, nwin:3,
              esum:64'h0000_0008_0000_0008, esat:4'h0};
    vt[1] = '{mode:1'b1, win_len:14'd10, s0:4'b0101, s1:4'b1001, en_tgl:1'b0, nwin:2,
              esum:64'h0000_0000_FFF6_000A, esat:4'h0};
    vt[2] = '{mode:1'b1, win_len:14'd1,  s0:4'b1010, s1:4'b1010, en_tgl:1'b0, nwin:4,
              esum:64'h0001_FFFF_0001_FFFF, esat:4'h0};
    vt[3] = '{mode:1'b0, win_len:14'd20, s0:4'b1111, s1:4'b1111, en_tgl:1'b0, nwin:1,
              esum:64'h0014_0014_0014_0014, esat:4'h0};
    vt[4] = '{mode:1'b0, win_len:14'd0,  s0:4'b1111, s1:4'b1111, en_tgl:1'b1, nwin:1,
              esum:64'h2710_2710_2710_2710, esat:4'h0};
    pat[0] = 4'b0001; pat[1] = 4'b0011; pat[2] = 4'b0111; pat[3] = 4'b1111;

    tick(); tick();
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {60'd0, out_valid, overrun, busy, |sat}, 64'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      int n;
      int per;
      n   = (vt[v].win_len == 0) ? 10000 : int'(vt[v].win_len);
      per = vt[v].en_tgl ? 2 : 1;
      out_ready = 1'b1; mode = vt[v].mode; win_len = vt[v].win_len;
      start = 1'b1; en = 1'b0; mon_en = 1'b1;
      tick();
      start = 1'b0; start_cyc = cyc; last_cyc = cyc;
      chk("vec_busy", {63'd0, busy}, 64'd1);
      for (int k = 0; k < vt[v].nwin * n; k++) begin
        if (vt[v].en_tgl) begin
          en = 1'b0; sample = 4'b0000;
          tick();
        end
        en = 1'b1;
        sample = (k % 2 == 0) ? vt[v].s0 : vt[v].s1;
        if ((k + 1) % n == 0) exp_q.push_back('{vt[v].esum, vt[v].esat, n * per});
        tick();
      end
      en = 1'b0;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      chk("vec_drain", 64'(exp_q.size()), 64'd0);
      tick();
      chk("vec_idle_valid", {63'd0, out_valid}, 64'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("vec_stop_busy", {63'd0, busy}, 64'd0);
    end
    mon_en = 1'b0;

    // Back-pressure: three unconsumed windows, then a consume on the 4th window end.
    out_ready = 1'b0; mode = 1'b0; win_len = 14'd4; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0; en = 1'b1;
    for (int w = 0; w < 4; w++) begin
      sample = pat[w];
      for (int k = 0; k < 4; k++) begin
        if (w == 3 && k == 3) out_ready = 1'b1;
        tick();
      end
      if (w == 0) chk("bp_w1_ovr", {62'd0, out_valid, overrun}, 64'd2);
      if (w == 2) begin
        chk("bp_w3_sum", sum, 64'h0000_0004_0004_0004);
        chk("bp_w3_flags", {62'd0, out_valid, overrun}, 64'd3);
      end
    end
    chk("bp_coinc_flags", {62'd0, out_valid, overrun}, 64'd3);
    chk("bp_coinc_sum", sum, 64'h0004_0004_0004_0004);
    en = 1'b0;
    tick();
    chk("bp_consumed", {62'd0, out_valid, overrun}, 64'd1);
    out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_ovr_clr", {62'd0, busy, overrun}, 64'd2);

    // Saturation: narrow instance clamps, wide instance does not.
    mode = 1'b0; win_len = 14'd20; sample = 4'b1111; en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("sat_u_sum_s", {48'd0, sum_s}, 64'h0000_0000_0000_FFFF);
    chk("sat_u_sat_s", {60'd0, sat_s}, 64'hF);
    chk("sat_u_sum", sum, 64'h0014_0014_0014_0014);
    chk("sat_u_sat", {60'd0, sat}, 64'h0);
    mode = 1'b1; sample = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("sat_s_sum_s", {48'd0, sum_s}, 64'h0000_0000_0000_8888);
    chk("sat_s_sat_s", {60'd0, sat_s}, 64'hF);
    chk("sat_s_sum", sum, 64'hFFEC_FFEC_FFEC_FFEC);

    // Abort after 5 of 8, en ignored in IDLE, then a clean window.
    en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0; mode = 1'b0; win_len = 14'd8; sample = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1;
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", {62'd0, busy, out_valid}, 64'd0);
    repeat (3) tick();
    chk("idle_en_ignored", {62'd0, busy, out_valid}, 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("restart_no_early", {63'd0, out_valid}, 64'd0);
    tick();
    chk("restart_valid", {63'd0, out_valid}, 64'd1);
    chk("restart_sum", sum, 64'h0008_0008_0008_0008);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_wins", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-window.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("arst_sum", sum, 64'd0);
    chk("arst_flags", {60'd0, out_valid, overrun, busy, |sat}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("post_rst_sum", sum, 64'h0008_0008_0008_0008);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
